// File: rtl/fb_arbiter.sv
// fb_arbiter: owns the single-port framebuffer RAM and shares it between display fetch, clear engine and CPU.
// Latency: display data valid 2 cycles after disp_req (fixed); CPU ack 2 cycles after issue.
// Backpressure: display is never stalled; clear yields to display; the CPU waits for a free port and no active clear.
module fb_arbiter #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 16,
    parameter int LORES_WORDS = 128,
    parameter int HIRES_WORDS = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hires,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    // The clear counter is one bit wider than the address so a full
    // 512-word clear can be expressed without wrapping.
    localparam logic [ADDR_W:0] LEN_LO  = (ADDR_W+1)'(LORES_WORDS);
    localparam logic [ADDR_W:0] LEN_HI  = (ADDR_W+1)'(HIRES_WORDS);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_DATA = 2'd1,
        CPU_ACK  = 2'd2
    } cpuState_t;

    cpuState_t       state;
    cpuState_t       stateNext;
    logic            grantDisp;
    logic            grantClr;
    logic            grantCpu;
    logic            cpuIsRead;
    logic            dispPend;
    logic [ADDR_W:0] clrCnt;
    logic [ADDR_W:0] clrLen;

    // Per-cycle port grant: display > clear > CPU issue. Reset blocks every
    // grant so an aborted clear or access cannot write in the reset cycle.
    always_comb begin
        grantDisp = disp_req && !reset;
        grantClr  = !reset && !disp_req && clr_busy && (state == IDLE);
        grantCpu  = !reset && !disp_req && !clr_busy && !clr_start
                    && cpu_req && (state == IDLE);
    end

    // Drive the RAM port from whichever requester owns it this cycle.
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (grantDisp) begin
            ram_addr = disp_addr;
        end else if (grantClr) begin
            ram_addr = clrCnt[ADDR_W-1:0];
            ram_we   = 1'b1;
        end else if (grantCpu) begin
            ram_addr  = cpu_addr;
            ram_we    = cpu_we;
            ram_wdata = cpu_wdata;
        end
    end

    // CPU access state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // CPU access sequencing: issue, wait one cycle for RAM data, then ack.
    always_comb begin
        stateNext = state;
        cpu_ack   = 1'b0;
        case (state)
            IDLE: begin
                if (grantCpu) begin
                    stateNext = CPU_DATA;
                end
            end
            CPU_DATA: begin
                stateNext = CPU_ACK;
            end
            CPU_ACK: begin
                cpu_ack   = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Remember access direction at issue; capture read data when it returns.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpuIsRead <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            if (grantCpu) begin
                cpuIsRead <= !cpu_we;
            end
            if (state == CPU_DATA && cpuIsRead) begin
                cpu_rdata <= ram_rdata;
            end
        end
    end

    // Fixed two-stage display pipeline: request, then capture, then valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            dispPend   <= 1'b0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
        end else begin
            dispPend   <= grantDisp;
            disp_valid <= dispPend;
            if (dispPend) begin
                disp_data <= ram_rdata;
            end
        end
    end

    // Clear engine: latch length at start, advance only on granted writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_busy <= 1'b0;
            clrCnt   <= '0;
            clrLen   <= '0;
        end else if (clr_start && !clr_busy) begin
            clr_busy <= 1'b1;
            clrCnt   <= '0;
            clrLen   <= hires ? LEN_HI : LEN_LO;
        end else if (grantClr) begin
            if (clrCnt + CNT_ONE == clrLen) begin
                clr_busy <= 1'b0;
                clrCnt   <= '0;
            end else begin
                clrCnt <= clrCnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: drives fb_arbiter with directed and random traffic against a behavioural RAM and port model.
// Latency: expectations derived per cycle from the arbitration rules; RAM contents compared at the end.
// Backpressure: CPU request held until the modelled ack, dropped the cycle after.
module tb_fb_arbiter;

    localparam int AW = 9;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          hires = 1'b0;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic [DW-1:0] disp_data;
    logic          disp_valid;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          clr_start = 1'b0;
    logic          clr_busy;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    fb_arbiter dut (
        .clk(clk), .reset(reset), .hires(hires),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Reference contents of the framebuffer, also the preload source.
    logic [DW-1:0] refMem [512];
    logic [DW-1:0] mem    [512];
    logic          preload = 1'b1;

    // Synchronous single-port RAM, read-before-write, one cycle read latency.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 512; i++) mem[i] <= refMem[i];
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Behavioural model state.
    bit            mBusy = 0;
    int            mCnt = 0;
    int            mLen = 0;
    int            cpuAge = -1;     // -1 none, 1 = data cycle, 2 = ack cycle
    bit            cpuWant = 0;
    bit            cpuPendRead = 0;
    logic [DW-1:0] cpuPendData = '0;
    logic [DW-1:0] mCpuRdata = '0;
    logic [DW-1:0] mDispData = '0;
    int            dueQ[$];
    logic [DW-1:0] valQ[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: predict port use, check at negedge, advance model.
    task automatic cycle();
        bit            expWe;
        logic [AW-1:0] expAddr;
        logic [DW-1:0] expWd;
        bit            clrWrite;
        bit            issue;
        bit            dispExp;
        expWe = 0; expAddr = '0; expWd = '0; clrWrite = 0; issue = 0;
        cpu_req = cpuWant;
        if (!reset) begin
            if (disp_req) begin
                expAddr = disp_addr;
                dueQ.push_back(cyc + 2);
                valQ.push_back(refMem[disp_addr]);
            end else if (mBusy && cpuAge < 0) begin
                clrWrite = 1; expWe = 1; expAddr = mCnt[AW-1:0]; expWd = '0;
            end else if (cpuAge < 0 && cpuWant && !mBusy && !clr_start) begin
                issue = 1; expAddr = cpu_addr; expWe = cpu_we; expWd = cpu_wdata;
            end
        end
        @(negedge clk);
        chk("ram_we", 32'(ram_we), 32'(expWe));
        chk("ram_addr", 32'(ram_addr), 32'(expAddr));
        if (expWe) chk("ram_wdata", 32'(ram_wdata), 32'(expWd));
        chk("clr_busy", 32'(clr_busy), 32'(mBusy));
        chk("cpu_ack", 32'(cpu_ack), 32'(cpuAge == 2));
        dispExp = (dueQ.size() > 0) && (dueQ[0] == cyc);
        chk("disp_valid", 32'(disp_valid), 32'(dispExp));
        if (dispExp) begin
            mDispData = valQ[0];
            void'(dueQ.pop_front());
            void'(valQ.pop_front());
        end
        chk("disp_data", 32'(disp_data), 32'(mDispData));
        if (cpuAge == 2 && cpuPendRead) mCpuRdata = cpuPendData;
        chk("cpu_rdata", 32'(cpu_rdata), 32'(mCpuRdata));
        if (reset) begin
            mBusy = 0; mCnt = 0; cpuAge = -1; cpuWant = 0;
            mCpuRdata = '0; mDispData = '0;
            dueQ.delete(); valQ.delete();
        end else begin
            if (issue) begin
                cpuPendRead = !cpu_we;
                cpuPendData = refMem[cpu_addr];
                if (cpu_we) refMem[cpu_addr] = cpu_wdata;
                cpuAge = 1;
            end else if (cpuAge == 1) begin
                cpuAge = 2;
            end else if (cpuAge == 2) begin
                cpuAge = -1;
                cpuWant = 0;
            end
            if (clrWrite) begin
                refMem[mCnt] = '0;
                mCnt++;
                if (mCnt == mLen) mBusy = 0;
            end else if (clr_start && !mBusy) begin
                mBusy = 1; mCnt = 0; mLen = hires ? 512 : 128;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        disp_req  = 1'b0;
        clr_start = 1'b0;
    endtask

    task automatic startCpu(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_we = we; cpu_addr = a; cpu_wdata = d; cpuWant = 1;
    endtask

    task automatic runCpu();
        for (int n = 0; n < 60 && cpuWant; n++) cycle();
    endtask

    task automatic runIdle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    int            cnt;
    int            c0;
    int            ackCyc;
    int            lastBusy;
    logic [DW-1:0] saved;

    initial begin
        for (int i = 0; i < 512; i++) refMem[i] = DW'($urandom);
        // Reset, then release with preloaded RAM.
        repeat (2) @(posedge clk);
        #1;
        preload = 1'b0;
        cycle();
        reset = 1'b0;
        chk("rst_clr_busy", 32'(clr_busy), 0);
        chk("rst_cpu_ack", 32'(cpu_ack), 0);
        chk("rst_disp_valid", 32'(disp_valid), 0);
        chk("rst_disp_data", 32'(disp_data), 0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
        runIdle(2);

        // Display streaming, addresses 0..7 back to back.
        cnt = 0;
        for (int a = 0; a < 12; a++) begin
            if (a < 8) begin disp_req = 1'b1; disp_addr = AW'(a); end
            cycle();
            if (disp_valid) cnt++;
        end
        chk("stream_valid_count", 32'(cnt), 8);

        // CPU write then read back.
        startCpu(1'b1, 9'h1F3, 16'hA5A5);
        runCpu();
        startCpu(1'b0, 9'h1F3, 16'h0000);
        runCpu();
        chk("cpu_read_a5a5", 32'(cpu_rdata), 32'h0000A5A5);

        // Contention: display takes three cycles, CPU issues on the fourth.
        c0 = cyc; ackCyc = -1;
        startCpu(1'b0, 9'h055, '0);
        for (int i = 0; i < 10; i++) begin
            if (i < 3) begin disp_req = 1'b1; disp_addr = AW'(10 + i); end
            cycle();
            if (cpu_ack && ackCyc < 0) ackCyc = cyc;
        end
        chk("contention_ack_latency", 32'(ackCyc - c0), 5);

        // Lores clear with no display traffic.
        saved = refMem[128];
        hires = 1'b0; clr_start = 1'b1;
        cycle();
        cnt = 0;
        for (int i = 0; i < 140; i++) begin
            if (clr_busy) cnt++;
            cycle();
        end
        chk("lores_busy_cycles", 32'(cnt), 128);
        chk("lores_word127", 32'(mem[127]), 0);
        chk("lores_word128_kept", 32'(mem[128]), 32'(saved));

        // Hires clear with display every other cycle; CPU raised mid-clear.
        hires = 1'b1;
        cnt = 0; ackCyc = -1; lastBusy = -1;
        for (int i = 0; i < 1200; i++) begin
            if (i == 0) clr_start = 1'b1;
            if (i == 300) hires = 1'b0;
            if (i % 2 == 0) begin disp_req = 1'b1; disp_addr = AW'($urandom); end
            if (i == 100) startCpu(1'b1, 9'h0A0, 16'h1234);
            cycle();
            if (clr_busy) begin cnt++; lastBusy = cyc; end
            if (cpu_ack) ackCyc = cyc;
        end
        chk("hires_busy_cycles", 32'(cnt), 1023);
        chk("cpu_ack_after_clear", 32'(ackCyc > lastBusy && lastBusy > 0), 1);
        chk("hires_word511", 32'(mem[511]), 0);
        chk("cpu_write_after_clear", 32'(mem[9'h0A0]), 32'h1234);

        // Reset mid-clear once the next write would target address 40.
        for (int i = 0; i < 512; i++) refMem[i] = mem[i] ^ 16'hFFFF;
        for (int i = 0; i < 512; i++) begin
            cpu_we = 1'b1; cpu_addr = AW'(i); cpu_wdata = refMem[i];
            refMem[i] = mem[i];
            cpuWant = 1;
            runCpu();
        end
        hires = 1'b0; clr_start = 1'b1;
        cycle();
        for (int n = 0; n < 200 && mCnt < 40; n++) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("reset_abort_busy", 32'(clr_busy), 0);
        runIdle(150);
        chk("reset_word39_cleared", 32'(mem[39]), 0);
        chk("reset_word40_kept", 32'(mem[40]), 32'(refMem[40]));
        chk("reset_word41_kept", 32'(mem[41]), 32'(refMem[41]));
        clr_start = 1'b1;
        cycle();
        chk("restart_addr0", 32'(ram_addr), 0);
        chk("restart_we", 32'(ram_we), 1);
        runIdle(140);

        // Clear requested while a CPU access is in flight.
        startCpu(1'b0, 9'h1F3, '0);
        cycle();
        clr_start = 1'b1; hires = 1'b0;
        cycle();
        runIdle(140);

        // Random mixed traffic.
        for (int i = 0; i < 3000; i++) begin
            disp_req  = 1'($urandom_range(0, 1));
            disp_addr = AW'($urandom);
            if (!cpuWant && $urandom_range(0, 4) == 0)
                startCpu(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
            if ($urandom_range(0, 300) == 0) begin
                clr_start = 1'b1;
                hires = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 100) == 0) hires = ~hires;
            if (i == 1700) reset = 1'b1;
            cycle();
            reset = 1'b0;
        end
        runIdle(1100);
        for (int i = 0; i < 512; i++) chk("final_mem", 32'(mem[i]), 32'(refMem[i]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
